// File: rtl/genius_controller.sv
// genius_controller: Simon-style game flow. Plays the first `level` colours of the
// sequence memory, then checks the player's presses against it.
module genius_controller #(
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       btn_valid_i,
    input  logic [1:0] btn_color_i,
    input  logic [1:0] seq_color_i,
    output logic [3:0] seq_index_o,
    output logic       led_on_o,
    output logic [1:0] led_color_o,
    output logic       input_ready_o,
    output logic [4:0] level_o,
    output logic       win_o,
    output logic       game_over_o
);
    localparam int MAX_SG = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = MAX_SG > TIMEOUT_CYCLES ? MAX_SG : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(MAX_C) + 1;
    localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SHOW_ON, SHOW_OFF, PAUSE, WAIT_INPUT, LOSE, WIN} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    seq_index_q, seq_index_d;
    logic [4:0]    level_q, level_d;
    logic          win_q, win_d, game_over_q, game_over_d;
    logic          led_on_q, input_ready_q;
    logic          last, tz;

    assign last = seq_index_q == 4'(level_q - 5'd1);
    assign tz   = timer_q == '0;

    always_comb begin
        state_d     = state_q;
        timer_d     = tz ? timer_q : timer_q - 1'b1;
        seq_index_d = seq_index_q;
        level_d     = level_q;
        win_d       = win_q;
        game_over_d = game_over_q;
        case (state_q)
            IDLE, LOSE, WIN: if (start_i) begin
                state_d     = SHOW_ON;
                timer_d     = SHOW_LD;
                seq_index_d = '0;
                level_d     = 5'd1;
                win_d       = 1'b0;
                game_over_d = 1'b0;
            end
            SHOW_ON: if (tz) begin
                state_d = SHOW_OFF;
                timer_d = GAP_LD;
            end
            SHOW_OFF: if (tz) begin
                state_d     = last ? WAIT_INPUT : SHOW_ON;
                timer_d     = last ? TO_LD : SHOW_LD;
                seq_index_d = last ? 4'd0 : seq_index_q + 4'd1;
            end
            PAUSE: if (tz) begin
                state_d     = SHOW_ON;
                timer_d     = SHOW_LD;
                seq_index_d = '0;
            end
            WAIT_INPUT: begin
                // A press always wins over a timer expiring in the same cycle
                if (btn_valid_i) begin
                    if (btn_color_i != seq_color_i) begin
                        state_d     = LOSE;
                        seq_index_d = '0;
                        game_over_d = 1'b1;
                    end else if (!last) begin
                        seq_index_d = seq_index_q + 4'd1;
                        timer_d     = TO_LD;
                    end else if (level_q == 5'd16) begin
                        state_d     = WIN;
                        seq_index_d = '0;
                        win_d       = 1'b1;
                    end else begin
                        state_d     = PAUSE;
                        seq_index_d = '0;
                        level_d     = level_q + 5'd1;
                        timer_d     = GAP_LD;
                    end
                end else if (tz) begin
                    state_d     = LOSE;
                    seq_index_d = '0;
                    game_over_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            seq_index_q   <= '0;
            level_q       <= '0;
            win_q         <= 1'b0;
            game_over_q   <= 1'b0;
            led_on_q      <= 1'b0;
            input_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            seq_index_q   <= seq_index_d;
            level_q       <= level_d;
            win_q         <= win_d;
            game_over_q   <= game_over_d;
            led_on_q      <= state_d == SHOW_ON;
            input_ready_q <= state_d == WAIT_INPUT;
        end
    end

    assign seq_index_o   = seq_index_q;
    assign led_on_o      = led_on_q;
    assign led_color_o   = led_on_q ? seq_color_i : 2'd0;
    assign input_ready_o = input_ready_q;
    assign level_o       = level_q;
    assign win_o         = win_q;
    assign game_over_o   = game_over_q;
endmodule

// File: tb/tb_genius_controller.sv
// tb_genius_controller: directed + randomized game play checked against expected
// timings derived from the playback/press rules.
module tb_genius_controller;
    localparam int SC = 4, GC = 2, TO = 16;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0, seq_color;
    logic [3:0] seq_index;
    logic       led_on, input_ready, win, game_over;
    logic [1:0] led_color;
    logic [4:0] level;
    logic [1:0] mem [16];
    int vectors = 0, miscompares = 0;
    bit noise = 1'b0;

    always #5 clk = ~clk;
    assign seq_color = mem[seq_index];

    genius_controller #(.SHOW_CYCLES(SC), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .btn_valid_i(btn_valid),
        .btn_color_i(btn_color), .seq_color_i(seq_color), .seq_index_o(seq_index),
        .led_on_o(led_on), .led_color_o(led_color), .input_ready_o(input_ready),
        .level_o(level), .win_o(win), .game_over_o(game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idx"}, seq_index, 0);
        check({tag, "_led"}, led_on, 0);
        check({tag, "_color"}, led_color, 0);
        check({tag, "_rdy"}, input_ready, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_over"}, game_over, 0);
    endtask

    // Random start/press pulses in states that must ignore them
    task automatic drive_noise();
        start     = noise && ($urandom_range(0, 7) == 0);
        btn_valid = noise && ($urandom_range(0, 5) == 0);
        btn_color = 2'($urandom_range(0, 3));
    endtask

    task automatic quiet();
        start     = 1'b0;
        btn_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        @(negedge clk);
        btn_valid = 1'b0;
    endtask

    task automatic play(input int lvl);
        for (int i = 0; i < lvl; i++) begin
            for (int c = 0; c < SC; c++) begin
                check("show_led", led_on, 1);
                check("show_color", led_color, mem[i]);
                check("show_idx", seq_index, i);
                check("show_rdy", input_ready, 0);
                drive_noise();
                @(negedge clk);
            end
            for (int c = 0; c < GC; c++) begin
                check("gap_led", led_on, 0);
                check("gap_color", led_color, 0);
                drive_noise();
                @(negedge clk);
            end
        end
        quiet();
        check("play_rdy", input_ready, 1);
        check("play_idx", seq_index, 0);
        check("play_led", led_on, 0);
        check("play_level", level, lvl);
    endtask

    task automatic pause(input int lvl);
        for (int c = 0; c < GC; c++) begin
            check("pause_led", led_on, 0);
            check("pause_rdy", input_ready, 0);
            check("pause_level", level, lvl);
            drive_noise();
            @(negedge clk);
        end
        quiet();
    endtask

    task automatic wait_ready(input int n);
        for (int k = 0; k < n; k++) begin
            check("wait_rdy", input_ready, 1);
            check("wait_over", game_over, 0);
            start = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        mem = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1,
                2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
        btn_valid = 1'b1;
        btn_color = 2'd2;
        #3 check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            check_idle("idle_btn");
            @(negedge clk);
        end
        btn_valid = 1'b0;

        // Level 1, advance, level 2 playback
        do_start();
        play(1);
        press(2'd2);
        check("adv_level", level, 2);
        check("adv_rdy", input_ready, 0);
        check("adv_idx", seq_index, 0);
        pause(2);
        play(2);

        // Wrong press at level 2
        press(2'd2);
        check("wp_idx", seq_index, 1);
        check("wp_rdy1", input_ready, 1);
        press(2'd0);
        check("wp_over", game_over, 1);
        check("wp_level", level, 2);
        check("wp_rdy", input_ready, 0);
        check("wp_idx0", seq_index, 0);
        repeat (3) @(negedge clk);
        check("wp_hold", game_over, 1);
        do_start();
        check("rs_level", level, 1);
        check("rs_over", game_over, 0);
        check("rs_led", led_on, 1);

        // Timeout with no press
        play(1);
        wait_ready(TO);
        check("to_over", game_over, 1);
        check("to_level", level, 1);
        check("to_rdy", input_ready, 0);

        // Press in the expiry cycle is accepted and reloads the timer
        do_start();
        play(1);
        wait_ready(TO - 1);
        press(mem[0]);
        check("late_level", level, 2);
        check("late_over", game_over, 0);
        pause(2);
        play(2);
        wait_ready(TO - 1);
        press(mem[0]);
        check("reload_idx", seq_index, 1);
        check("reload_over", game_over, 0);
        wait_ready(TO - 1);
        press(mem[1]);
        check("reload_level", level, 3);
        pause(3);
        play(3);
        press(2'd3);
        check("c3_over", game_over, 1);
        check("c3_level", level, 3);

        // Full randomized game with ignored start/press noise
        for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 2));
        do_start();
        noise = 1'b1;
        for (int lv = 1; lv <= 16; lv++) begin
            play(lv);
            for (int i = 0; i < lv; i++) begin
                wait_ready($urandom_range(0, 10));
                press(mem[i]);
                if (i < lv - 1) begin
                    check("fg_idx", seq_index, i + 1);
                    check("fg_rdy", input_ready, 1);
                end else if (lv < 16) begin
                    check("fg_level", level, lv + 1);
                    check("fg_idx0", seq_index, 0);
                end
            end
            if (lv < 16) pause(lv + 1);
        end
        noise = 1'b0;
        quiet();
        check("win", win, 1);
        check("win_level", level, 16);
        check("win_over", game_over, 0);
        check("win_rdy", input_ready, 0);
        check("win_idx", seq_index, 0);
        check("win_led", led_on, 0);
        repeat (3) @(negedge clk);
        check("win_hold", win, 1);

        // Press during SHOW_ON is ignored; async reset mid-show
        do_start();
        check("ws_clr", win, 0);
        press(mem[0]);
        check("ign_idx", seq_index, 0);
        check("ign_led", led_on, 1);
        check("ign_level", level, 1);
        #2 rst_n = 1'b0;
        #1 check_idle("async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/genius_controller.md
# genius_controller

Game-flow controller for the Genius (Simon) game. It sequences the 16-entry colour sequence memory by driving its index, and plays the first `level` colours on the LED outputs. It then collects player button presses, checks each one against the memory, and either advances the level, declares a win at level 16, or declares game over on a wrong press or timeout. It sits between the sequence memory, the button debouncers and the LED/display drivers.

## Interface
- `SHOW_CYCLES`, default 4: cycles each colour is lit during playback (≥1).
- `GAP_CYCLES`, default 2: dark cycles after each lit colour, and pause before each replay (≥1).
- `TIMEOUT_CYCLES`, default 16: maximum wait for each player press (≥1).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that starts a new game.
- `btn_valid`  in  1  single-cycle pulse: one player press.
- `btn_color`  in  2  colour of the press, valid with `btn_valid`. Values 0, 1 and 2 are legal; 3 is always wrong.
- `seq_color`  in  2  colour read from the sequence memory at `seq_index` (combinational).
- `seq_index`  out  4  index into the sequence memory (registered).
- `led_on`  out  1  LED lit (registered).
- `led_color`  out  2  equals `seq_color` when `led_on` is 1, otherwise 0.
- `input_ready`  out  1  controller is waiting for a press (registered).
- `level`  out  5  current level, 1..16; 0 after reset (registered).
- `win`  out  1  game won; held until the next `start`.
- `game_over`  out  1  game lost; held until the next `start`.

## Operation
- States: IDLE, SHOW_ON, SHOW_OFF, PAUSE, WAIT_INPUT, LOSE, WIN.
- Reset (async): state IDLE. All of the following are 0: `seq_index`, `led_on`, `led_color`, `input_ready`, `level`, `win`, `game_over`, timer.
- IDLE, LOSE and WIN accept `start`:
  - set `level` to 1, `seq_index` to 0, and clear `win` and `game_over`;
  - go to SHOW_ON.
- `start` is ignored in every other state.
- SHOW_ON: `led_on`=1 for `SHOW_CYCLES` cycles, then go to SHOW_OFF.
- SHOW_OFF: `led_on`=0 for `GAP_CYCLES` cycles. When it ends:
  - if `seq_index` == `level`-1 (4-bit compare): set `seq_index` to 0 and go to WAIT_INPUT;
  - otherwise increment `seq_index` and go to SHOW_ON.
- WAIT_INPUT: `input_ready`=1. The timeout timer loads `TIMEOUT_CYCLES` on entry and again after each correct press. On `btn_valid`:
  - `btn_color` ≠ `seq_color`: go to LOSE.
  - Match and `seq_index` < `level`-1: increment `seq_index` and stay in WAIT_INPUT.
  - Match on the last element and `level`=16: go to WIN.
  - Match on the last element and `level`<16: increment `level`, set `seq_index` to 0, go to PAUSE.
- PAUSE: `GAP_CYCLES` dark cycles, then go to SHOW_ON with `seq_index` 0.
- WAIT_INPUT timeout (timer expires without a press): go to LOSE.
- `btn_valid` is ignored outside WAIT_INPUT.
- LOSE: `game_over`=1. `level` holds the level reached, which serves as the score.
- WIN: `win`=1, `level`=16.
- In LOSE and WIN, `seq_index`, `led_on` and `input_ready` are 0.
- `level` never exceeds 16. `seq_index` never wraps, because the index limit is `level`-1 ≤ 15.

## Timing
- `start` sampled at edge E0: `led_on` rises at E0 and stays high for `SHOW_CYCLES` cycles, then stays low for `GAP_CYCLES` cycles.
- Playback of level L takes L·(`SHOW_CYCLES`+`GAP_CYCLES`) cycles. `input_ready` rises on the edge that ends the last gap.
- A press sampled at edge Ep takes effect at Ep:
  - `seq_index`, `level`, `game_over` and `win` update at Ep;
  - `input_ready` falls at Ep when leaving WAIT_INPUT.
- Timeout: with no press, LOSE is entered at the `TIMEOUT_CYCLES`-th edge after WAIT_INPUT entry or after the last correct press.
- Press in the same cycle as timer expiry: the press is evaluated and the timeout is discarded.
- `rst_n` low mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. Operation resumes from IDLE only after the next `start`.

## Test plan
- Reset then idle. Stimulus: pulse `rst_n` low; drive `btn_valid` with colour 2. Required: all outputs stay 0 and the state stays IDLE.
- Level 1 play and advance (defaults; memory pattern 2,1,0,1,0,2,...). Stimulus: `start`, then press 2 after `input_ready` rises.
  - `led_on`=1 with `led_color`=2 for 4 cycles, then 2 dark cycles.
  - `input_ready` rises 6 cycles after E0.
  - After the press: `level`=2, 2 PAUSE cycles, then playback of 2 and 1.
- Wrong press. Stimulus: at level 2, press 2 then 0 (expected 1). Required: `game_over`=1 at the second press edge, `level` stays 2, `input_ready`=0. A following `start` restarts at `level`=1 and clears `game_over`.
- Timeout. Stimulus: no press for 16 cycles in WAIT_INPUT. Required: `game_over`=1 on the 16th edge. Also: a correct press in the 16th cycle is accepted and the timer reloads.
- Full game. Stimulus: correct presses through all 16 levels. Required: `win`=1 and `level`=16; `start` is ignored during play and during WAIT_INPUT.
- Abuse cases:
  - press with `btn_color`=3: goes to LOSE;
  - `rst_n` asserted during SHOW_ON: `led_on` falls with no clock edge;
  - `btn_valid` during SHOW_ON: ignored, with no change to `seq_index`.
